// File: rtl/neuron_layer_sequencer.sv
// Sequences a fully-connected layer: MAC over inputs, quantise, write per output.
// Define NEURON_RELU_EN for unsigned ReLU output instead of signed saturation.
module neuron_layer_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_base,
  input  logic [7:0]        out_base,
  input  logic [7:0]        n_inputs,
  input  logic [7:0]        n_outputs,
  output logic              busy,
  output logic              done,
  output logic [15:0]       w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [7:0]        ram_read_address,
  output logic              ram_oe,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [7:0]        ram_write_address,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_wre
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE,
    DONE
  } state_t;

  localparam int PW = 2 * DATA_W + 1;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q;
  logic [7:0] i_q, j_q;
  logic [7:0] in_base_q, out_base_q;
  logic [7:0] n_in_q, n_out_q;

  logic signed [DATA_W:0]   din_s;
  logic signed [DATA_W-1:0] w_s;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        q_out;
  logic                     last_i;
  logic                     last_j;

  // Input neurons are unsigned activations; weights are signed.
  assign din_s    = $signed({1'b0, ram_read_data});
  assign w_s      = $signed(w_data);
  assign prod     = din_s * w_s;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign shifted  = acc_q >>> SHIFT;

  assign last_i = (i_q == n_in_q - 8'd1);
  assign last_j = ({1'b0, j_q} + 9'd1 >= {1'b0, n_out_q});

`ifdef NEURON_RELU_EN
  localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((1 << DATA_W) - 1);

  always_comb begin
    q_out = shifted[DATA_W-1:0];
    if (shifted < 0) begin
      q_out = '0;
    end else if (shifted > UMAX) begin
      q_out = '1;
    end
  end
`else
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = -ACC_W'(1 << (DATA_W-1));

  always_comb begin
    q_out = shifted[DATA_W-1:0];
    if (shifted > SMAX) begin
      q_out = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SMIN) begin
      q_out = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      n_in_q     <= '0;
      n_out_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            in_base_q  <= in_base;
            out_base_q <= out_base;
            n_in_q     <= n_inputs;
            n_out_q    <= n_outputs;
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_q + prod_ext;
          i_q   <= i_q + 8'd1;
        end
        WRITE: begin
          acc_q <= '0;
          i_q   <= '0;
          if (!last_j) begin
            j_q <= j_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_inputs == 8'd0 || n_outputs == 8'd0) begin
            state_d = DONE;
          end else begin
            state_d = MAC;
          end
        end
      end
      MAC: begin
        if (last_i) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = last_j ? DONE : MAC;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write strobe is gated by rst_n so a reset edge never commits a write.
  always_comb begin
    busy              = 1'b0;
    done              = 1'b0;
    ram_oe            = 1'b0;
    ram_wre           = 1'b0;
    ram_read_address  = '0;
    w_addr            = '0;
    ram_write_address = '0;
    ram_write_data    = '0;
    case (state_q)
      MAC: begin
        busy             = 1'b1;
        ram_oe           = 1'b1;
        ram_read_address = in_base_q + i_q;
        w_addr = {8'd0, j_q} * {8'd0, n_in_q} + {8'd0, i_q};
      end
      WRITE: begin
        busy              = 1'b1;
        ram_wre           = rst_n;
        ram_write_address = out_base_q + j_q;
        ram_write_data    = q_out;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer with RAM and weight models.
// Expected outputs follow NEURON_RELU_EN when that macro is defined.
module tb_neuron_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_base, out_base, n_inputs, n_outputs;
  logic        busy, done;
  logic [15:0] w_addr;
  logic [7:0]  w_data;
  logic [7:0]  ram_read_address;
  logic        ram_oe;
  logic [7:0]  ram_read_data;
  logic [7:0]  ram_write_address;
  logic [7:0]  ram_write_data;
  logic        ram_wre;

  logic [7:0] ram  [256];
  logic [7:0] wmem [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_a, pl_d;

  int oe_cnt = 0, wre_cnt = 0, done_cnt = 0;
  int rd_log[$];
  int wa_log[$];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  neuron_layer_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .in_base           (in_base),
    .out_base          (out_base),
    .n_inputs          (n_inputs),
    .n_outputs         (n_outputs),
    .busy              (busy),
    .done              (done),
    .w_addr            (w_addr),
    .w_data            (w_data),
    .ram_read_address  (ram_read_address),
    .ram_oe            (ram_oe),
    .ram_read_data     (ram_read_data),
    .ram_write_address (ram_write_address),
    .ram_write_data    (ram_write_data),
    .ram_wre           (ram_wre)
  );

  assign ram_read_data = ram[ram_read_address];
  assign w_data        = wmem[w_addr[7:0]];

  always @(posedge clk) begin
    if (pl_we) begin
      ram[pl_a] <= pl_d;
    end else if (ram_wre) begin
      ram[ram_write_address] <= ram_write_data;
    end
  end

  always @(negedge clk) begin
    if (ram_oe) begin
      oe_cnt <= oe_cnt + 1;
      rd_log.push_back(int'(ram_read_address));
      wa_log.push_back(int'(w_addr));
    end
    if (ram_wre) wre_cnt <= wre_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ram_put(input logic [7:0] a, input logic [7:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_we = 1'b1;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  // Accepts one layer, scrambles config afterwards, returns cycles to done.
  task automatic run(input logic [7:0] ib, input logic [7:0] ob,
                     input logic [7:0] ni, input logic [7:0] no,
                     input bit poke, output int lat);
    in_base   = ib;
    out_base  = ob;
    n_inputs  = ni;
    n_outputs = no;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    in_base   = 8'h5A;
    out_base  = 8'hC3;
    n_inputs  = 8'd3;
    n_outputs = 8'd2;
    lat = 1;
    while (!done && lat < 400) begin
      start = (poke && lat == 2);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  int lat, oe0, wre0, dn0, lg0;
  int exp_rd[8];
  int exp_wa[8];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_base = '0;
    out_base = '0;
    n_inputs = '0;
    n_outputs = '0;
    for (int k = 0; k < 256; k++) wmem[k] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_oe", {31'd0, ram_oe}, 32'd0);
    chk("rst_wre", {31'd0, ram_wre}, 32'd0);
    chk("rst_raddr", {24'd0, ram_read_address}, 32'd0);
    chk("rst_waddr", {16'd0, w_addr}, 32'd0);
    chk("rst_wraddr", {24'd0, ram_write_address}, 32'd0);
    chk("rst_wrdata", {24'd0, ram_write_data}, 32'd0);
    rst_n = 1'b1;

    // 7+2+3+1 with unit weights
    ram_put(0, 7); ram_put(1, 2); ram_put(2, 3); ram_put(3, 1);
    ram_put(16, 8'h55);
    for (int k = 0; k < 4; k++) wmem[k] = 8'd1;
    oe0 = oe_cnt; wre0 = wre_cnt; dn0 = done_cnt; lg0 = rd_log.size();
    run(0, 16, 4, 1, 1'b0, lat);
    chk("sum_latency", lat, 6);
    chk("sum_result", {24'd0, ram[16]}, 32'd13);
    chk("sum_oe_cycles", oe_cnt - oe0, 4);
    chk("sum_wre_cycles", wre_cnt - wre0, 1);
    chk("sum_done_pulses", done_cnt - dn0, 1);
    for (int k = 0; k < 4; k++) chk("sum_rd_addr", rd_log[lg0+k], k);

    // negative weights
    for (int k = 0; k < 4; k++) wmem[k] = 8'hFF;
    run(0, 16, 4, 1, 1'b0, lat);
`ifdef NEURON_RELU_EN
    chk("neg_result", {24'd0, ram[16]}, 32'h00);
`else
    chk("neg_result", {24'd0, ram[16]}, 32'hF3);
`endif

    // positive saturation
    ram_put(0, 255); ram_put(1, 255);
    wmem[0] = 8'd127; wmem[1] = 8'd127;
    run(0, 16, 2, 1, 1'b0, lat);
    chk("sat_latency", lat, 4);
`ifdef NEURON_RELU_EN
    chk("sat_result", {24'd0, ram[16]}, 32'hFF);
`else
    chk("sat_result", {24'd0, ram[16]}, 32'h7F);
`endif

    // address wrap and two outputs
    ram_put(254, 10); ram_put(255, 20); ram_put(0, 30); ram_put(1, 40);
    wmem[0] = 8'd1; wmem[1] = 8'd0; wmem[2] = 8'd0; wmem[3] = 8'd1;
    wmem[4] = 8'd0; wmem[5] = 8'd1; wmem[6] = 8'hFF; wmem[7] = 8'd0;
    exp_rd = '{254, 255, 0, 1, 254, 255, 0, 1};
    exp_wa = '{0, 1, 2, 3, 4, 5, 6, 7};
    lg0 = rd_log.size(); wre0 = wre_cnt;
    run(254, 100, 4, 2, 1'b0, lat);
    chk("wrap_latency", lat, 11);
    chk("wrap_log_len", rd_log.size() - lg0, 8);
    for (int k = 0; k < 8; k++) begin
      chk("wrap_rd_addr", rd_log[lg0+k], exp_rd[k]);
      chk("wrap_w_addr", wa_log[lg0+k], exp_wa[k]);
    end
    chk("wrap_out0", {24'd0, ram[100]}, 32'd50);
`ifdef NEURON_RELU_EN
    chk("wrap_out1", {24'd0, ram[101]}, 32'h00);
`else
    chk("wrap_out1", {24'd0, ram[101]}, 32'hF6);
`endif
    chk("wrap_writes", wre_cnt - wre0, 2);

    // output range overlaps input range
    ram_put(0, 3); ram_put(1, 4); ram_put(2, 0);
    wmem[0] = 8'd1; wmem[1] = 8'd0; wmem[2] = 8'd1; wmem[3] = 8'd1;
    run(0, 1, 2, 2, 1'b0, lat);
    chk("ovl_latency", lat, 7);
    chk("ovl_out0", {24'd0, ram[1]}, 32'd3);
    chk("ovl_out1", {24'd0, ram[2]}, 32'd6);

    // reset on the second MAC cycle
    ram_put(0, 7); ram_put(1, 2); ram_put(2, 3); ram_put(3, 1);
    ram_put(16, 8'h55);
    for (int k = 0; k < 4; k++) wmem[k] = 8'd1;
    wre0 = wre_cnt; dn0 = done_cnt;
    in_base = 0; out_base = 16; n_inputs = 4; n_outputs = 1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_oe", {31'd0, ram_oe}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_write", wre_cnt - wre0, 0);
    chk("midrst_no_done", done_cnt - dn0, 0);
    chk("midrst_ram16", {24'd0, ram[16]}, 32'h55);

    // rerun with a start pulse while busy
    dn0 = done_cnt;
    run(0, 16, 4, 1, 1'b1, lat);
    chk("rerun_latency", lat, 6);
    chk("rerun_result", {24'd0, ram[16]}, 32'd13);
    repeat (4) @(posedge clk);
    #1;
    chk("rerun_done_pulses", done_cnt - dn0, 1);
    chk("rerun_idle", {31'd0, busy}, 32'd0);

    // zero counts
    oe0 = oe_cnt; wre0 = wre_cnt;
    run(0, 50, 0, 3, 1'b0, lat);
    chk("zero_in_latency", lat, 1);
    run(0, 50, 3, 0, 1'b0, lat);
    chk("zero_out_latency", lat, 1);
    chk("zero_oe", oe_cnt - oe0, 0);
    chk("zero_wre", wre_cnt - wre0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
